// File: rtl/mandlebrot_pkg.sv
// Shared types and byte constants for the Mandelbrot ASCII scan-out path.
package mandlebrot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SEND,
        EOL,
        DONE
    } state_t;

    localparam logic [7:0] SH_0       = 8'h20;  // ' '
    localparam logic [7:0] SH_1       = 8'h2E;  // '.'
    localparam logic [7:0] SH_2       = 8'h3A;  // ':'
    localparam logic [7:0] SH_3       = 8'h2B;  // '+'
    localparam logic [7:0] SH_4       = 8'h23;  // '#'
    localparam logic [7:0] NL_DEFAULT = 8'h0A;

endpackage

// File: rtl/mandlebrot_ascii_scanout_ascii_shade.sv
// Maps a full-width iteration count to its ASCII shade byte; purely combinational.
module ascii_shade
    import mandlebrot_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_q,
    output logic [7:0]            o_byte
);

    // Compare against the whole count so large values never alias onto low shades.
    always_comb begin
        if (i_q == DATA_WIDTH'(0))
            o_byte = SH_0;
        else if (i_q == DATA_WIDTH'(1))
            o_byte = SH_1;
        else if (i_q == DATA_WIDTH'(2))
            o_byte = SH_2;
        else if (i_q == DATA_WIDTH'(3))
            o_byte = SH_3;
        else
            o_byte = SH_4;
    end

endmodule

// File: rtl/mandlebrot_ascii_scanout.sv
// Sweeps the iteration framebuffer once per start and streams it as ASCII text,
// one byte per pixel with a NEWLINE after every LINE_LEN pixels.
module mandlebrot_ascii_scanout
    import mandlebrot_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         ADDR_WIDTH = 9,
    parameter int         LINE_LEN   = 32,
    parameter logic [7:0] NEWLINE    = NL_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int                    LINE_W    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam logic [LINE_W-1:0]     LAST_LINE = LINE_W'(LINE_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_raddr, w_raddr_nxt;
    logic [LINE_W-1:0]     r_line,  w_line_nxt;
    logic [7:0]            r_data,  w_data_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_busy,  w_busy_nxt;
    logic [7:0]            w_shade;
    logic                  w_xfer;

    ascii_shade #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shade (
        .i_q   (q),
        .o_byte(w_shade)
    );

    assign w_xfer = r_valid & m_ready;

    // NOTE: every output of this block is assigned its hold value first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_raddr_nxt = r_raddr;
        w_line_nxt  = r_line;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = FETCH;
                    w_busy_nxt  = 1'b1;
                    w_raddr_nxt = '0;
                    w_line_nxt  = '0;
                end
            end
            FETCH: w_state_nxt = LATCH;
            LATCH: begin
                w_data_nxt  = w_shade;
                w_valid_nxt = 1'b1;
                w_state_nxt = SEND;
            end
            SEND: begin
                if (w_xfer) begin
                    if (r_line == LAST_LINE) begin
                        // Newline is loaded straight away so it costs one cycle, not three.
                        w_data_nxt  = NEWLINE;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = EOL;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_raddr_nxt = r_raddr + ADDR_WIDTH'(1);
                        w_line_nxt  = r_line + LINE_W'(1);
                        w_state_nxt = FETCH;
                    end
                end
            end
            EOL: begin
                if (w_xfer) begin
                    w_valid_nxt = 1'b0;
                    if (r_raddr == LAST_ADDR) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_raddr_nxt = r_raddr + ADDR_WIDTH'(1);
                        w_line_nxt  = '0;
                        w_state_nxt = FETCH;
                    end
                end
            end
            DONE: begin
                w_busy_nxt  = 1'b0;
                w_raddr_nxt = '0;
                w_line_nxt  = '0;
                w_valid_nxt = 1'b0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raddr <= '0;
            r_line  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_raddr <= w_raddr_nxt;
            r_line  <= w_line_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign raddr      = r_raddr;
    assign m_data     = r_data;
    assign m_valid    = r_valid;
    assign busy       = r_busy;
    assign frame_done = (r_state == DONE);

endmodule
